// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared constants, status bit map and helpers for the SPI target.
package spi_target_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned BYTE_W = 8;

    // Register select (address bit 2 decoded by the bus fabric)
    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    // STATUS / CTRL bit indices
    localparam int unsigned ST_RX_NE     = 0;
    localparam int unsigned ST_RX_FULL   = 1;
    localparam int unsigned ST_TX_EMPTY  = 2;
    localparam int unsigned ST_RX_OVR    = 3;
    localparam int unsigned ST_TX_UDR    = 4;
    localparam int unsigned ST_CS_ACTIVE = 5;
    localparam int unsigned ST_TX_OVR    = 6;
    localparam int unsigned ST_IRQ_EN    = 8;

    // Value returned by a DATA read with the RX FIFO empty
    localparam logic [DATA_W-1:0] EMPTY_READ = 32'hFFFF_FFFF;

    // Assemble the STATUS read word; unlisted bits read 0
    function automatic logic [DATA_W-1:0] pack_status(
        input logic rx_ne,
        input logic rx_full,
        input logic tx_empty,
        input logic rx_ovr,
        input logic tx_udr,
        input logic cs_active,
        input logic tx_ovr,
        input logic irq_en
    );
        logic [DATA_W-1:0] s;
        s               = '0;
        s[ST_RX_NE]     = rx_ne;
        s[ST_RX_FULL]   = rx_full;
        s[ST_TX_EMPTY]  = tx_empty;
        s[ST_RX_OVR]    = rx_ovr;
        s[ST_TX_UDR]    = tx_udr;
        s[ST_CS_ACTIVE] = cs_active;
        s[ST_TX_OVR]    = tx_ovr;
        s[ST_IRQ_EN]    = irq_en;
        return s;
    endfunction

endpackage

// File: rtl/spi_target_if.sv
// spi_target_if: CPU-side valid/ready register bus of the SPI target.
//   master: valid, ctrl (register select), wstrb, wdata -> ; <- rdata, ready, irq
//   slave : mirror of master
interface spi_target_if;
    import spi_target_pkg::*;

    logic              valid;
    logic              ctrl;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              irq;

    modport master (output valid, ctrl, wstrb, wdata, input rdata, ready, irq);
    modport slave  (input valid, ctrl, wstrb, wdata, output rdata, ready, irq);
endinterface

// File: rtl/spi_target_fifo.sv
// spi_target_fifo: DEPTH x 8 synchronous FIFO; simultaneous push and pop both succeed.
//   push/din   : write a byte (ignored when full)
//   pop        : drop the head (ignored when empty)
//   dout_c     : head byte, ne_c: not empty, full_c: full (combinational from state)
module spi_target_fifo
    import spi_target_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout_c,
    output logic              ne_c,
    output logic              full_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0][BYTE_W-1:0] mem_q, mem_d;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         do_push, do_pop;

    assign ne_c    = (cnt_q != '0);
    assign full_c  = (cnt_q == CW'(DEPTH));
    assign dout_c  = mem_q[rd_ptr_q];
    assign do_push = push & ~full_c;
    assign do_pop  = pop & ne_c;

    // Pointer and count update; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_target.sv
// spi_target: mode-3 SPI target with CPU register window (DATA / STATUS-CTRL).
//   clk, rst_n         : system clock, synchronous active-low reset
//   bus (slave)        : valid/ready register bus, level irq
//   spi_cen/sclk/mosi  : SPI pins from the external master (asynchronous)
//   spi_miso, _oe      : serial data out and its output enable
module spi_target
    import spi_target_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2   // minimum 2
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_target_if.slave  bus,
    input  logic         spi_cen,
    input  logic         spi_sclk,
    input  logic         spi_mosi,
    output logic         spi_miso,
    output logic         spi_miso_oe
);
    localparam int unsigned SW = SYNC_STAGES;

    // Synchronizers; sync_vld marks when the chains hold only real pin samples
    logic [SW-1:0] sclk_sync_q, sclk_sync_d;
    logic [SW-1:0] cen_sync_q,  cen_sync_d;
    logic [SW-1:0] mosi_sync_q, mosi_sync_d;
    logic [SW-1:0] sync_vld_q,  sync_vld_d;

    logic sclk_s, cen_s, mosi_s;
    logic sclk_prev_q, sclk_prev_d;
    logic cen_prev_q,  cen_prev_d;
    logic sclk_rise, sclk_fall, cen_fall;

    logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
    logic [2:0]        bit_cnt_q,  bit_cnt_d;
    logic              frame_q, frame_d;
    logic              first_fall_q, first_fall_d;
    logic              load_pending_q, load_pending_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic              tx_udr_q, tx_udr_d;
    logic              tx_ovr_q, tx_ovr_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              acc, wr_req, rd_req, tx_load;
    logic              fifo_push, fifo_pop, fifo_ne, fifo_full;
    logic [BYTE_W-1:0] fifo_dout, rx_byte;
    logic              unused_wdata;

    assign unused_wdata = ^{bus.wdata[DATA_W-1:9], bus.wdata[5], bus.wdata[2:0]};

    assign sclk_sync_d = {sclk_sync_q[SW-2:0], spi_sclk};
    assign cen_sync_d  = {cen_sync_q[SW-2:0],  spi_cen};
    assign mosi_sync_d = {mosi_sync_q[SW-2:0], spi_mosi};
    assign sync_vld_d  = {sync_vld_q[SW-2:0],  1'b1};

    assign sclk_s = sclk_sync_q[SW-1];
    assign cen_s  = cen_sync_q[SW-1];
    assign mosi_s = mosi_sync_q[SW-1];

    // cen_prev stays 0 until real samples arrive, so a cen held low through
    // reset is never mistaken for a fresh frame start
    assign sclk_prev_d = sclk_s;
    assign cen_prev_d  = sync_vld_q[SW-1] ? cen_s : 1'b0;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cen_fall  = ~cen_s & cen_prev_q;

    assign acc     = bus.valid & ~ready_q;
    assign wr_req  = acc & (|bus.wstrb);
    assign rd_req  = acc & ~(|bus.wstrb);
    assign rx_byte = {rx_shift_q[6:0], mosi_s};

    // Next-state for SPI engine, holding register, sticky flags and bus response
    always_comb begin
        tx_shift_d     = tx_shift_q;
        rx_shift_d     = rx_shift_q;
        bit_cnt_d      = bit_cnt_q;
        frame_d        = frame_q;
        first_fall_d   = first_fall_q;
        load_pending_d = load_pending_q;
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        rx_ovr_d       = rx_ovr_q;
        tx_udr_d       = tx_udr_q;
        tx_ovr_d       = tx_ovr_q;
        irq_en_d       = irq_en_q;
        irq_d          = irq_en_q & fifo_ne;
        ready_d        = acc;
        rdata_d        = '0;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        tx_load        = 1'b0;

        // CTRL write first, so a sticky flag set in the same cycle survives
        if (wr_req && bus.ctrl == REG_STAT) begin
            irq_en_d = bus.wdata[ST_IRQ_EN];
            if (bus.wdata[ST_RX_OVR]) rx_ovr_d = 1'b0;
            if (bus.wdata[ST_TX_UDR]) tx_udr_d = 1'b0;
            if (bus.wdata[ST_TX_OVR]) tx_ovr_d = 1'b0;
        end

        if (cen_fall) begin
            frame_d        = 1'b1;
            bit_cnt_d      = '0;
            rx_shift_d     = '0;
            load_pending_d = 1'b0;
            first_fall_d   = 1'b1;
            tx_load        = 1'b1;
        end else if (cen_s) begin
            // Deselected (or aborted): drop any partial byte
            frame_d        = 1'b0;
            bit_cnt_d      = '0;
            rx_shift_d     = '0;
            load_pending_d = 1'b0;
            first_fall_d   = 1'b0;
        end else if (frame_q) begin
            if (sclk_rise) begin
                rx_shift_d = rx_byte;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    load_pending_d = 1'b1;
                    if (fifo_full) rx_ovr_d  = 1'b1;
                    else           fifo_push = 1'b1;
                end
            end else if (sclk_fall) begin
                // The first fall of a frame only re-drives bit 7 loaded at cen fall
                if (load_pending_q) begin
                    tx_load        = 1'b1;
                    load_pending_d = 1'b0;
                end else if (first_fall_q) begin
                    first_fall_d = 1'b0;
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
        end

        if (tx_load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = '0;
                tx_udr_d   = 1'b1;
            end
        end

        // DATA write after the SPI load, so a freed holding register accepts it
        if (wr_req && bus.ctrl == REG_DATA && bus.wstrb[0]) begin
            if (hold_full_d) begin
                tx_ovr_d = 1'b1;
            end else begin
                hold_d      = bus.wdata[BYTE_W-1:0];
                hold_full_d = 1'b1;
            end
        end

        if (rd_req) begin
            if (bus.ctrl == REG_DATA) begin
                if (fifo_ne) begin
                    rdata_d  = {24'h0, fifo_dout};
                    fifo_pop = 1'b1;
                end else begin
                    rdata_d = EMPTY_READ;
                end
            end else begin
                rdata_d = pack_status(fifo_ne, fifo_full, ~hold_full_q, rx_ovr_q,
                                      tx_udr_q, ~cen_s, tx_ovr_q, irq_en_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q    <= '1;
            cen_sync_q     <= '1;
            mosi_sync_q    <= '0;
            sync_vld_q     <= '0;
            sclk_prev_q    <= 1'b1;
            cen_prev_q     <= 1'b0;
            tx_shift_q     <= '0;
            rx_shift_q     <= '0;
            bit_cnt_q      <= '0;
            frame_q        <= 1'b0;
            first_fall_q   <= 1'b0;
            load_pending_q <= 1'b0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            rx_ovr_q       <= 1'b0;
            tx_udr_q       <= 1'b0;
            tx_ovr_q       <= 1'b0;
            irq_en_q       <= 1'b0;
            irq_q          <= 1'b0;
            ready_q        <= 1'b0;
            rdata_q        <= '0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            cen_sync_q     <= cen_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            sync_vld_q     <= sync_vld_d;
            sclk_prev_q    <= sclk_prev_d;
            cen_prev_q     <= cen_prev_d;
            tx_shift_q     <= tx_shift_d;
            rx_shift_q     <= rx_shift_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_q        <= frame_d;
            first_fall_q   <= first_fall_d;
            load_pending_q <= load_pending_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            rx_ovr_q       <= rx_ovr_d;
            tx_udr_q       <= tx_udr_d;
            tx_ovr_q       <= tx_ovr_d;
            irq_en_q       <= irq_en_d;
            irq_q          <= irq_d;
            ready_q        <= ready_d;
            rdata_q        <= rdata_d;
        end
    end

    spi_target_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (fifo_push),
        .din    (rx_byte),
        .pop    (fifo_pop),
        .dout_c (fifo_dout),
        .ne_c   (fifo_ne),
        .full_c (fifo_full)
    );

    assign bus.rdata   = rdata_q;
    assign bus.ready   = ready_q;
    assign bus.irq     = irq_q;
    assign spi_miso    = tx_shift_q[7];
    assign spi_miso_oe = ~cen_s;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed bench for spi_target acting as CPU and external SPI master.
module tb_spi_target;
    import spi_target_pkg::*;

    localparam int HALF = 6;   // SCLK half period in clk cycles

    logic clk;
    logic rst_n;
    logic spi_cen, spi_sclk, spi_mosi, spi_miso, spi_miso_oe;
    int   checks;
    int   errors;

    spi_target_if bus();

    spi_target #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .spi_cen     (spi_cen),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus transaction; returns rdata/ready sampled while ready should be high
    task automatic bus_xfer(input logic c, input logic [3:0] s, input logic [31:0] d,
                            output logic [31:0] rd, output logic rdy);
        @(negedge clk);
        bus.valid = 1'b1; bus.ctrl = c; bus.wstrb = s; bus.wdata = d;
        @(negedge clk);
        bus.valid = 1'b0; bus.wstrb = 4'h0; bus.wdata = '0;
        rd  = bus.rdata;
        rdy = bus.ready;
    endtask

    task automatic spi_start();
        @(negedge clk);
        spi_cen = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_end();
        spi_cen = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi_sclk = 1'b0;
            spi_mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic rdy;
        checks++; if (bus.ready !== 1'b0)   begin errors++; $display("FAIL reset_ready got %h exp 0", bus.ready); end
        checks++; if (bus.rdata !== 32'h0)  begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.rdata); end
        checks++; if (bus.irq !== 1'b0)     begin errors++; $display("FAIL reset_irq got %h exp 0", bus.irq); end
        checks++; if (spi_miso !== 1'b0)    begin errors++; $display("FAIL reset_miso got %h exp 0", spi_miso); end
        checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %h exp 0", spi_miso_oe); end
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h04) begin errors++; $display("FAIL reset_status got %h exp 00000004", rd); end
    endtask

    task automatic test_single_byte();
        logic [31:0] rd; logic rdy; logic [7:0] rx;
        bus_xfer(REG_DATA, 4'h1, 32'hA5, rd, rdy);
        spi_start();
        spi_bits(8'h3C, 8, rx);
        checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL single_miso got %h exp a5", rx); end
        checks++; if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL single_oe got %h exp 1", spi_miso_oe); end
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL single_ready got %h exp 1", rdy); end
        checks++; if (rd !== 32'h25) begin errors++; $display("FAIL single_stat_active got %h exp 00000025", rd); end
        spi_end();
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h05) begin errors++; $display("FAIL single_stat_idle got %h exp 00000005", rd); end
        bus_xfer(REG_DATA, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h3C) begin errors++; $display("FAIL single_pop got %h exp 0000003c", rd); end
        @(negedge clk);
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL single_rdata_idle got %h exp 0", bus.rdata); end
        bus_xfer(REG_DATA, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_empty got %h exp ffffffff", rd); end
    endtask

    task automatic test_multi_byte();
        logic [31:0] rd; logic rdy; logic [7:0] rx; logic [7:0] exp_rx [3]; logic [7:0] tx [3];
        int polls;
        exp_rx[0] = 8'h11; exp_rx[1] = 8'h22; exp_rx[2] = 8'h00;
        tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03;
        bus_xfer(REG_DATA, 4'h1, 32'h11, rd, rdy);
        spi_start();
        polls = 0;
        rd = '0;
        while (!rd[ST_TX_EMPTY] && polls < 20) begin
            bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
            polls++;
        end
        checks++; if (rd[ST_TX_EMPTY] !== 1'b1) begin errors++; $display("FAIL multi_tx_empty_timeout got %h exp 1", rd[ST_TX_EMPTY]); end
        bus_xfer(REG_DATA, 4'h1, 32'h22, rd, rdy);
        for (int b = 0; b < 3; b++) begin
            spi_bits(tx[b], 8, rx);
            checks++; if (rx !== exp_rx[b]) begin errors++; $display("FAIL multi_miso%0d got %h exp %h", b, rx, exp_rx[b]); end
        end
        spi_end();
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h15) begin errors++; $display("FAIL multi_status got %h exp 00000015", rd); end
        for (int b = 0; b < 3; b++) begin
            bus_xfer(REG_DATA, 4'h0, 32'h0, rd, rdy);
            checks++; if (rd !== {24'h0, tx[b]}) begin errors++; $display("FAIL multi_pop%0d got %h exp %h", b, rd, tx[b]); end
        end
        bus_xfer(REG_STAT, 4'h1, 32'h10, rd, rdy);
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h04) begin errors++; $display("FAIL multi_udr_clear got %h exp 00000004", rd); end
    endtask

    task automatic test_overrun();
        logic [31:0] rd; logic rdy; logic [7:0] rx;
        spi_start();
        for (int b = 0; b < 5; b++) spi_bits(8'hA1 + 8'(b), 8, rx);
        spi_end();
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h1F) begin errors++; $display("FAIL ovr_status got %h exp 0000001f", rd); end
        for (int b = 0; b < 4; b++) begin
            bus_xfer(REG_DATA, 4'h0, 32'h0, rd, rdy);
            checks++; if (rd !== 32'hA1 + 32'(b)) begin errors++; $display("FAIL ovr_pop%0d got %h exp %h", b, rd, 32'hA1 + 32'(b)); end
        end
        bus_xfer(REG_DATA, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovr_empty got %h exp ffffffff", rd); end
        bus_xfer(REG_STAT, 4'h1, 32'h08, rd, rdy);
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h14) begin errors++; $display("FAIL ovr_clear got %h exp 00000014", rd); end
        bus_xfer(REG_STAT, 4'h1, 32'h10, rd, rdy);
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic rdy; logic [7:0] rx;
        spi_start();
        spi_bits(8'hE0, 3, rx);
        spi_end();
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h14) begin errors++; $display("FAIL abort_status got %h exp 00000014", rd); end
        spi_start();
        spi_bits(8'h5A, 8, rx);
        spi_end();
        bus_xfer(REG_DATA, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h5A) begin errors++; $display("FAIL abort_next got %h exp 0000005a", rd); end
        bus_xfer(REG_STAT, 4'h1, 32'h10, rd, rdy);
    endtask

    task automatic test_tx_ovr();
        logic [31:0] rd; logic rdy;
        bus_xfer(REG_DATA, 4'h1, 32'h33, rd, rdy);
        bus_xfer(REG_DATA, 4'h1, 32'h44, rd, rdy);
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h40) begin errors++; $display("FAIL txovr_status got %h exp 00000040", rd); end
        bus_xfer(REG_STAT, 4'h1, 32'h40, rd, rdy);
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h00) begin errors++; $display("FAIL txovr_clear got %h exp 00000000", rd); end
    endtask

    task automatic test_interrupt();
        logic [31:0] rd; logic rdy; logic [7:0] rx;
        bus_xfer(REG_STAT, 4'h1, 32'h100, rd, rdy);
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h100) begin errors++; $display("FAIL irq_en_status got %h exp 00000100", rd); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %h exp 0", bus.irq); end
        spi_start();
        spi_bits(8'h77, 8, rx);
        spi_end();
        checks++; if (rx !== 8'h33) begin errors++; $display("FAIL irq_miso got %h exp 33", rx); end
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_set got %h exp 1", bus.irq); end
        bus_xfer(REG_DATA, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h77) begin errors++; $display("FAIL irq_pop got %h exp 00000077", rd); end
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_during_ready got %h exp 1", bus.irq); end
        @(negedge clk);
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_after_ready got %h exp 0", bus.irq); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd; logic rdy; logic [7:0] rx;
        bus_xfer(REG_STAT, 4'h1, 32'h100, rd, rdy);
        spi_start();
        spi_bits(8'hEE, 8, rx);
        spi_end();
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL rst_pre_irq got %h exp 1", bus.irq); end
        bus_xfer(REG_DATA, 4'h1, 32'hFF, rd, rdy);
        spi_start();
        spi_bits(8'h00, 3, rx);
        spi_sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        checks++; if (spi_miso !== 1'b1) begin errors++; $display("FAIL rst_pre_miso got %h exp 1", spi_miso); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.irq !== 1'b0)     begin errors++; $display("FAIL rst_irq got %h exp 0", bus.irq); end
        checks++; if (spi_miso !== 1'b0)    begin errors++; $display("FAIL rst_miso got %h exp 0", spi_miso); end
        checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %h exp 0", spi_miso_oe); end
        checks++; if (bus.ready !== 1'b0)   begin errors++; $display("FAIL rst_ready got %h exp 0", bus.ready); end
        rst_n = 1'b1;
        spi_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_bits(8'hFF, 4, rx);
        spi_end();
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h04) begin errors++; $display("FAIL rst_status got %h exp 00000004", rd); end
        spi_start();
        spi_bits(8'hC3, 8, rx);
        spi_end();
        bus_xfer(REG_STAT, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'h15) begin errors++; $display("FAIL rst_after_status got %h exp 00000015", rd); end
        bus_xfer(REG_DATA, 4'h0, 32'h0, rd, rdy);
        checks++; if (rd !== 32'hC3) begin errors++; $display("FAIL rst_after_pop got %h exp 000000c3", rd); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        spi_cen = 1'b1; spi_sclk = 1'b1; spi_mosi = 1'b0;
        bus.valid = 1'b0; bus.ctrl = 1'b0; bus.wstrb = 4'h0; bus.wdata = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_overrun();
        test_abort();
        test_tx_ovr();
        test_interrupt();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (slave) peripheral: the responder counterpart of the CPOL=1 SPI master already on the SoC I/O bus. An external SPI master clocks bytes in on `spi_mosi` while the block returns bytes on `spi_miso`. The CPU sees a two-register window on the same valid/ready bus as the other I/O devices. Received bytes are buffered in a small FIFO, and transmit bytes are staged in a one-entry holding register.

## Interface
- `FIFO_DEPTH`, 4: RX FIFO entries; power of 2, minimum 2.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `spi_sclk`, `spi_cen`, `spi_mosi`.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `valid`  in  1  bus request; the top gates it with `!ready`.
- `ctrl`  in  1  register select: 0 = DATA, 1 = STATUS/CTRL (decoded from address bit 2 by the top).
- `wstrb`  in  4  byte write strobes; nonzero means write.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; valid while `ready` is high.
- `ready`  out  1  single-cycle completion pulse.
- `irq`  out  1  level interrupt.
- `spi_cen`  in  1  chip enable, active-low, asynchronous to `clk`.
- `spi_sclk`  in  1  SPI clock, idles high (mode 3).
- `spi_mosi`  in  1  serial data in.
- `spi_miso`  out  1  serial data out.
- `spi_miso_oe`  out  1  output enable for `spi_miso`.

## Operation
- Reset values:
  - `ready`=0, `rdata`=0, `irq`=0, `spi_miso`=0, `spi_miso_oe`=0.
  - FIFO empty, holding register empty, all sticky flags 0, `irq_en`=0.
- DATA read:
  - FIFO not empty: `rdata`={24'h0, head byte}, and the head is popped.
  - FIFO empty: `rdata`=32'hFFFF_FFFF, no pop.
- DATA write (`wstrb[0]`):
  - Holding register empty: `wdata[7:0]` is loaded and the register marked full.
  - Holding register full: the write is dropped and `tx_ovr` is set.
- STATUS read bits:
  - [0] `rx_ne`, [1] `rx_full`, [2] `tx_empty`, [3] `rx_ovr`, [4] `tx_udr`, [5] `cs_active`, [8] `irq_en`.
  - All other bits read 0; `tx_ovr` reads at [6].
- CTRL write:
  - `wdata[8]` sets `irq_en`.
  - Writing 1 to bits [3], [4] or [6] clears the corresponding sticky flag.
- `irq` is registered: `irq` = `irq_en & rx_ne`.
- SPI mode 3: sample MOSI on a rising SCLK edge, drive MISO on a falling edge, MSB first.
- SPI control uses the synchronized signals and edge detects on the synchronized SCLK:
  - `cen` falls: `bit_cnt`=0, discard any partial RX byte, load the TX shifter. The source is the holding register if full (it becomes empty); otherwise 8'h00 and `tx_udr` is set.
  - Rising edge: `rx_shift`={`rx_shift[6:0]`, mosi}, `bit_cnt`++.
  - On the 8th rise (`bit_cnt` 7 to 0): push the byte to the FIFO and set `load_pending`.
  - FIFO full at that push: the byte is dropped and `rx_ovr` is set.
  - Falling edge: if `load_pending`, reload the TX shifter with the same rule as at `cen` fall and clear `load_pending`; otherwise shift left.
  - `cen` rises mid-byte: the partial byte is discarded and `bit_cnt`=0. A TX byte already loaded into the shifter is consumed, not restored.
- `spi_miso` = `tx_shift[7]`; `spi_miso_oe` = `cs_active` (= !synced cen).
- A pop and a push in the same cycle both succeed; the count is unchanged.
- A CPU write to a full holding register in the same cycle as an SPI load: the load happens first, so the write succeeds.

## Timing
- Bus handshake:
  - A request is accepted on a cycle with `valid` && !`ready`; side effects occur in that cycle.
  - `ready`=1 and `rdata` are registered and appear on the next cycle, for exactly one cycle.
  - `rdata` returns to 0 when `ready` is low.
- MOSI path: a byte is visible in STATUS `rx_ne` at most `SYNC_STAGES`+2 `clk` cycles after the 8th SCLK rising edge at the pin.
- MISO path: updates `SYNC_STAGES`+1 `clk` cycles after a falling SCLK pin edge or a `cen` fall.
- Minimum SCLK high and low time: `SYNC_STAGES`+2 `clk` periods.
- Minimum setup from a `cen` fall to the first SCLK fall: same figure.
- Reset mid-transfer: all state returns to the reset values in the next cycle. The first SPI byte after reset starts only at a fresh `cen` fall.

## Structure
- Package `spi_target_pkg`:
  - Register select constants `REG_DATA`=0 and `REG_STAT`=1.
  - Status bit indices.
  - Empty-read value 32'hFFFF_FFFF.
- Sub-module `spi_target_fifo`: synchronous FIFO (`FIFO_DEPTH` x 8) with push, pop, `ne`, `full`, and concurrent push/pop support.
- The top block contains the synchronizers, edge detection, shifters, holding register and bus logic.

## Test plan
- Single byte:
  - CPU writes DATA 0xA5; master sends 0x3C in one `cen` frame.
  - Master receives 0xA5; STATUS reads 0x25 (`rx_ne`, `tx_empty`, `cs_active` cleared after `cen` rises, giving 0x05); DATA read returns 0x3C; a second read returns 0xFFFF_FFFF.
- Multi-byte frame:
  - CPU preloads 0x11, then writes 0x22 once `tx_empty`; master sends 0x01, 0x02, 0x03.
  - MISO bytes are 0x11, 0x22, 0x00; `tx_udr`=1; FIFO pops in order 01, 02, 03.
- Overrun:
  - Master sends 5 bytes with `FIFO_DEPTH`=4 and no pops.
  - `rx_ovr`=1, `rx_full`=1; pops return bytes 1-4 only; writing 0x08 to CTRL clears `rx_ovr`.
- Abort:
  - `cen` rises after 3 bits.
  - No FIFO push; the next full frame byte is received intact.
- Interrupt:
  - Write CTRL 0x100, then master sends 1 byte.
  - `irq`=1 until the DATA pop; `irq` deasserts the cycle after `ready`.
- Reset mid-frame:
  - `rst_n`=0 for 1 cycle during bit 4.
  - All outputs return to their reset values; FIFO empty; a subsequent frame works.
